seg7_page_scan_ctrl: RTL and testbench
======================================

Name: seg7_page_scan_ctrl

Overview:
Controller that drives a multiplexed multi-digit 7-segment display from two BCD pages. It selects the page with a debounced page-flip button, time-multiplexes the digits, and decodes each BCD nibble to segments {a..g}. It sits between the application's BCD value registers and the board-level segment and digit-select pins. It replaces the static one-digit page decode with a clocked scanner.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 1000, clocks per digit slot (>=2)
DEBOUNCE_CYC, 20000, consecutive stable clocks needed to accept a button level change (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
page_btn  input  1  raw page-flip button, active-high, asynchronous to clk
page_a  input  4*DIGITS  page 0 BCD digits; nibble i is digit i, digit 0 rightmost
page_b  input  4*DIGITS  page 1 BCD digits, same layout
page  output  1  current page (0 = page_a, 1 = page_b)
seg  output  7  segments {a,b,c,d,e,f,g}, bit6 = a, active-high, registered
dig_sel_n  output  DIGITS  digit enables, active-low, one-hot-low, registered

Behaviour:
- Reset values (async on rst_n low):
  - page=0, seg=7'b0000000, dig_sel_n=all ones.
  - scan index=0, prescaler=0.
  - synchronizer flops=0, debounced level=0, debounce counter=0.
- Synchronizer: page_btn passes through a 2-flop synchronizer before any use.
- Debouncer:
  - Counter increments each clock while the synced level != debounced level.
  - Counter clears on any clock where they are equal.
  - When counter == DEBOUNCE_CYC-1 with inequality still present, the debounced level takes the synced level and the counter clears.
- Page toggle:
  - A rising edge of the debounced level toggles page on the next clock.
  - Falling edges do nothing.
  - Holding the button produces exactly one toggle.
  - Total latency from a clean page_btn rise to page toggling: 2 + DEBOUNCE_CYC + 1 clocks.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the wrap clock, the scan index increments, and wraps DIGITS-1 -> 0. With DIGITS=1 the index stays 0.
- Anti-ghost blanking: during the prescaler's final count (SCAN_DIV-1), the registered outputs are dig_sel_n=all ones and seg=0.
- Normal slot: otherwise, the registered outputs are:
  - dig_sel_n = all ones except bit[index]=0.
  - seg = decode(nibble[index] of the selected page).
  - Output latency is 1 clock from index, page or data change.
- Decode ({a..g}):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - 10..15 = 0000001 (dash, g only)
- Page change mid-slot: the new page's nibble appears on seg 1 clock after page toggles. The slot timing is not restarted.
- page_a/page_b are sampled live every clock and are not latched.
- Reset mid-operation: all state returns to reset values immediately. A press in progress is discarded.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: for the selected page, digit i (i>0) outputs seg=0 when its nibble and every higher nibble are 0. dig_sel_n is unchanged. Digit 0 is always displayed, so value 0 shows a single "0".
- Not defined: every digit is decoded as-is, zeros included.
- Scan timing and page logic are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then release -> page=0, seg=0000000, dig_sel_n=1111 until first slot output; first slot shows digit 0.
- Scan (DIGITS=4, SCAN_DIV=4, page_a=16'h4321) -> expected sequence:
  - dig_sel_n 1110/seg 0110000 for 3 clocks, then blank 1 clock.
  - Then 1101/1101101, 1011/1111001, 0111/0110011, each 3 clocks plus 1 blank.
  - Then wraps to digit 0.
- Bounce (DEBOUNCE_CYC=8): page_btn high 5 clocks, low 3, high 4, then low -> page never toggles.
- Valid press: page_btn high for 20 clocks with page_b=16'h0009 -> page goes 0->1 exactly 11 clocks after the rise. Digit 0 then shows 1111011. Holding high for 100 more clocks gives no further toggle.
- Invalid BCD: page_a nibble0=4'hC -> digit 0 slot shows seg=0000001.
- LEADING_ZERO_BLANK_EN, page_a=16'h0050:
  - Defined: digits 3 and 2 show seg=0, digit 1 shows 1011011, digit 0 shows 1111110.
  - Undefined: digits 3 and 2 show 1111110.

Source files
------------

// File: rtl/seg7_page_scan_ctrl.sv
// Two-page BCD 7-segment scanner with a debounced page-flip button.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits on the selected page.
module seg7_page_scan_ctrl #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 20000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  page_btn,
  input  logic [4*DIGITS-1:0]   page_a,
  input  logic [4*DIGITS-1:0]   page_b,
  output logic                  page,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel_n
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam int unsigned DebW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);
  localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYC - 1);

  logic [1:0]          sync_q;
  logic                deb_q, deb_d, deb_prev_q;
  logic [DebW-1:0]     deb_cnt_q, deb_cnt_d;
  logic                page_q, page_d;
  logic [PreW-1:0]     presc_q, presc_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic [4*DIGITS-1:0] page_sel;
  logic [3:0]          nib;
  logic                lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000001;
    endcase
  endfunction

  // Debounce: accept a new level only after DEBOUNCE_CYC consecutive differing clocks.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (deb_cnt_q == DebLast) begin
        deb_d = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Page flips one clock after a debounced rising edge.
  assign page_d = page_q ^ (deb_q & ~deb_prev_q);

  // Slot prescaler and digit index.
  always_comb begin
    presc_d = (presc_q == PreLast) ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PreLast) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  assign page_sel = page_q ? page_b : page_a;
  assign nib      = page_sel[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] zero_above;

  // zero_above[i] is set when nibble i and every higher nibble are zero.
  always_comb begin
    logic run;
    run = 1'b1;
    zero_above = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run = run & (page_sel[4*i +: 4] == 4'd0);
      zero_above[i] = run;
    end
    zero_above[0] = 1'b0;  // digit 0 always shown
  end

  assign lz_blank = zero_above[idx_q];
`else
  assign lz_blank = 1'b0;
`endif

  // Next registered outputs; the last prescaler count blanks to avoid ghosting.
  always_comb begin
    seg_d = '0;
    dig_d = '1;
    if (presc_q != PreLast) begin
      dig_d = ~(DIGITS'(1) << idx_q);
      seg_d = lz_blank ? 7'b0000000 : decode(nib);
    end
  end

  // All state, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      page_q     <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_q      <= '0;
      dig_q      <= '1;
    end else begin
      sync_q     <= {sync_q[0], page_btn};
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      page_q     <= page_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign page      = page_q;
  assign seg       = seg_q;
  assign dig_sel_n = dig_q;

endmodule

// File: tb/tb_seg7_page_scan_ctrl.sv
// Randomized bench for seg7_page_scan_ctrl against a cycle-count based reference model.
module tb_seg7_page_scan_ctrl;

  localparam int unsigned DIGITS       = 4;
  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CYC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        page_btn = 1'b0;
  logic [15:0] page_a = '0;
  logic [15:0] page_b = '0;
  logic        page;
  logic [6:0]  seg;
  logic [3:0]  dig_sel_n;

  seg7_page_scan_ctrl #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .page_btn  (page_btn),
    .page_a    (page_a),
    .page_b    (page_b),
    .page      (page),
    .seg       (seg),
    .dig_sel_n (dig_sel_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: time since reset gives the slot; button history gives the page.
  bit         m_hist1, m_hist2;     // button seen one and two edges ago
  bit         m_level, m_level_prev;
  int         m_diff_run;           // consecutive clocks the synced level has differed
  bit         m_page;
  int         m_k;                  // clock edges since reset release
  logic [6:0] m_seg;
  logic [3:0] m_dig;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    return (d < 10) ? tbl[d] : 7'b0000001;
  endfunction

  task automatic model_reset();
    m_hist1 = 0; m_hist2 = 0; m_level = 0; m_level_prev = 0;
    m_diff_run = 0; m_page = 0; m_k = 0;
    m_seg = '0; m_dig = '1;
  endtask

  task automatic model_edge();
    logic [15:0] v, hi;
    int idx;
    v = m_page ? page_b : page_a;
    if ((m_k % SCAN_DIV) == SCAN_DIV - 1) begin
      m_seg = '0;
      m_dig = '1;
    end else begin
      idx   = (m_k / SCAN_DIV) % DIGITS;
      hi    = v >> (4 * idx);
      m_dig = 4'hF & ~(4'h1 << idx);
      m_seg = seg_of(int'(hi & 16'hF));
`ifdef LEADING_ZERO_BLANK_EN
      if (idx > 0 && hi == 16'h0) m_seg = '0;
`endif
    end
    if (m_level && !m_level_prev) m_page = !m_page;
    m_level_prev = m_level;
    if (m_hist2 != m_level) begin
      m_diff_run++;
      if (m_diff_run == DEBOUNCE_CYC) begin
        m_level    = m_hist2;
        m_diff_run = 0;
      end
    end else begin
      m_diff_run = 0;
    end
    m_hist2 = m_hist1;
    m_hist1 = page_btn;
    m_k++;
  endtask

  // One clock: advance model, then compare 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_eq("seg", 32'(seg), 32'(m_seg));
    check_eq("dig_sel_n", 32'(dig_sel_n), 32'(m_dig));
    check_eq("page", 32'(page), 32'(m_page));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [15:0] rand_page();
    logic [15:0] masks [5];
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    return 16'($urandom) & masks[$urandom_range(0, 4)];
  endfunction

  initial begin
    logic start_page;
    int   lat;

    model_reset();
    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      page_btn = 1'($urandom);
      page_a   = 16'($urandom);
      page_b   = 16'($urandom);
      cycle();
    end
    page_btn = 1'b0;
    page_a   = 16'h4321;
    page_b   = 16'h0009;
    rst_n    = 1'b1;
    cycle();
    check_eq("first_slot_seg", 32'(seg), 32'(7'b0110000));
    check_eq("first_slot_dig", 32'(dig_sel_n), 32'(4'b1110));
    run(40);

    // Invalid BCD and leading-zero patterns
    page_a = 16'h000C;
    run(20);
    page_a = 16'h0050;
    run(20);
    page_a = 16'h0000;
    run(20);

    // Bounce shorter than the debounce window never toggles
    start_page = page;
    page_btn = 1'b1; run(5);
    page_btn = 1'b0; run(3);
    page_btn = 1'b1; run(4);
    page_btn = 1'b0; run(30);
    check_eq("bounce_no_toggle", 32'(page), 32'(start_page));

    // Clean press: measure latency, then hold with no further toggle
    start_page = page;
    page_btn = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (page != start_page) begin
        lat = i;
        break;
      end
    end
    check_eq("press_latency", 32'(lat), 32'd11);
    run(100);
    check_eq("hold_single_toggle", 32'(page), 32'(!start_page));
    page_btn = 1'b0;
    run(30);
    check_eq("release_no_toggle", 32'(page), 32'(!start_page));

    // Random button holds and page contents
    for (int blk = 0; blk < 60; blk++) begin
      page_btn = 1'($urandom);
      if ($urandom_range(0, 1) == 0) page_a = rand_page();
      if ($urandom_range(0, 1) == 0) page_b = rand_page();
      run($urandom_range(1, 14));
    end

    // Asynchronous reset in the middle of a press
    page_btn = 1'b1;
    run(6);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_seg", 32'(seg), 32'd0);
    check_eq("async_rst_dig", 32'(dig_sel_n), 32'hF);
    check_eq("async_rst_page", 32'(page), 32'd0);
    page_btn = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
